road_lane_ctrl: RTL and testbench
=================================

Name: road_lane_ctrl

Overview:
- Generates the moving car obstacles on the road section of the Frogger grid. The grid is 14 columns (X 0..13) by 15 rows (Y 0..14).
- Drives the collision input of the frog controller from the frog's registered X/Y position.
- Supplies per-cell car occupancy to the VGA renderer from the divided column/row counters.
- Sits directly upstream of frogger_ctrl.

Parameters:
- TICK_DIV, 1250000: i_Clk cycles per game tick (50 ms at 25 MHz); legal range 2..2^24-1.
- LANE_ROW0, 8: grid row of lane 0; lane k occupies row LANE_ROW0+k, k = 0..4.
- P0..P4, 4/3/5/2/6: game ticks between shifts of lane k; legal range 1..15.
- INIT0..INIT4, 14'h0C03/14'h0330/14'h1818/14'h0606/14'h2040: reset car pattern of lane k; bit c is column c.

Ports:
- i_Clk  in  1  system clock
- i_Rst_N  in  1  asynchronous active-low reset
- i_Game_Active  in  1  high = lanes move and collisions are reported
- i_Frogger_X  in  6  frog column, from frogger_ctrl
- i_Frogger_Y  in  6  frog row, from frogger_ctrl
- i_Col_Count_Div  in  6  renderer cell column
- i_Row_Count_Div  in  6  renderer cell row
- o_Collided  out  1  single-cycle hit pulse, to frogger_ctrl
- o_Car_Present  out  1  a car occupies the render cell
- o_Tick  out  1  single-cycle game-tick strobe
- o_Lane_Shift  out  5  bit k pulses for one cycle when lane k shifts

Behaviour:
- Reset (i_Rst_N low, asynchronous, takes effect immediately):
  - Lane k pattern = INITk.
  - Tick counter and all lane counters = 0.
  - o_Collided, o_Car_Present, o_Tick, o_Lane_Shift = 0; r_Hit_Prev = 0.
  - Release is synchronous to i_Clk. Reset mid-shift discards the shift.
- Tick counter:
  - 24-bit; counts 0..TICK_DIV-1 only while i_Game_Active = 1.
  - On the cycle it wraps to 0, o_Tick = 1 for exactly one cycle.
  - When i_Game_Active = 0: counter holds and o_Tick = 0.
- Lane counters:
  - 4-bit each. On a tick, counter k increments.
  - If counter k == Pk-1 on a tick: it clears to 0, lane k shifts, and o_Lane_Shift[k] = 1 on that same cycle.
  - All lanes with a due shift move in the same cycle.
- Shift direction and wrap:
  - Even lanes (0, 2, 4) rotate right: new[c] = old[c-1]; new[0] = old[13].
  - Odd lanes (1, 3) rotate left: new[c] = old[c+1]; new[13] = old[0].
  - Rotation never loses or creates cars: popcount is invariant.
- Inactive game (i_Game_Active = 0):
  - Patterns, lane counters and tick counter freeze.
  - o_Collided is forced 0; o_Car_Present still reflects the frozen patterns.
- Hit condition (combinational, from current registered patterns):
  - i_Game_Active = 1, and
  - LANE_ROW0 <= i_Frogger_Y <= LANE_ROW0+4, and
  - i_Frogger_X <= 13, and
  - pattern[Y-LANE_ROW0][X] = 1.
  - Out-of-range X (14..63) or Y = no hit.
- Collision pulse:
  - r_Hit_Prev is the registered hit condition.
  - o_Collided <= hit & ~r_Hit_Prev: one pulse per entry into an occupied cell.
  - Latency: one cycle after the frog moves into a car, or after a car shifts onto the frog. Both cases produce the same single pulse.
  - Frog moving and lane shifting in the same cycle: evaluate on the next-cycle values; at most one pulse.
  - A frog standing in a car cell that persists (frogger_ctrl has not yet moved it) pulses once only.
- Render lookup:
  - o_Car_Present <= (row in lane range) & (col <= 13) & pattern[row-LANE_ROW0][col].
  - One-cycle latency; ignores i_Game_Active.
- Width rules:
  - Row/column subtraction is done in 6 bits, and only after the range check.
  - Lane index is 3 bits; values 5..7 never occur.

Test Plan:
- Reset: TICK_DIV=4. Assert i_Rst_N=0 mid-count -> all outputs 0 immediately; after release, lane 0 = 14'h0C03 and lane 1 = 14'h0330.
- Tick/shift timing: TICK_DIV=4, i_Game_Active=1 -> o_Tick on cycles 4, 8, 12, 16. Lane 3 (P=2) shifts on ticks 2 and 4; lane 0 (P=4) shifts on tick 4, giving 14'h1806.
- Wrap: lane 0 = 14'h2001, one right shift -> 14'h0003. Lane 1 = 14'h2001, one left shift -> 14'h3000. Popcount checked on every shift.
- Freeze: drop i_Game_Active for 100 cycles -> no o_Tick or o_Lane_Shift, patterns unchanged, o_Collided=0 with the frog on a car. Re-raise -> counting resumes from the held count.
- Collision by frog move: frog (0,9), lane 1 bit 0 = 1, Y changes 10->9 -> o_Collided=1 for exactly one cycle, one cycle after the move. Holding the position gives no second pulse.
- Collision by car shift and bounds: frog (5,8), lane 0 bit 4 = 1, right shift -> single pulse next cycle. Frog X=14 or Y=13 -> never pulses. Render lookup of (3,12) returns pattern[4][3] one cycle later.

Source files
------------

// File: rtl/road_lane_ctrl.sv
// Road section of the Frogger grid: five rotating car lanes, frog collision
// detection and per-cell car occupancy for the renderer.
module road_lane_ctrl #(
  parameter int unsigned TICK_DIV  = 1250000,
  parameter int unsigned LANE_ROW0 = 8,
  parameter int unsigned P0        = 4,
  parameter int unsigned P1        = 3,
  parameter int unsigned P2        = 5,
  parameter int unsigned P3        = 2,
  parameter int unsigned P4        = 6,
  parameter logic [13:0] INIT0     = 14'h0C03,
  parameter logic [13:0] INIT1     = 14'h0330,
  parameter logic [13:0] INIT2     = 14'h1818,
  parameter logic [13:0] INIT3     = 14'h0606,
  parameter logic [13:0] INIT4     = 14'h2040
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Game_Active,
  input  logic [5:0] i_Frogger_X,
  input  logic [5:0] i_Frogger_Y,
  input  logic [5:0] i_Col_Count_Div,
  input  logic [5:0] i_Row_Count_Div,
  output logic       o_Collided,
  output logic       o_Car_Present,
  output logic       o_Tick,
  output logic [4:0] o_Lane_Shift
);

  localparam int unsigned NUM_LANES = 5;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [5:0]  ROW_FIRST = 6'(LANE_ROW0);
  localparam logic [5:0]  ROW_LAST  = 6'(LANE_ROW0 + 4);
  localparam logic [5:0]  COL_LAST  = 6'd13;

  localparam logic [4:0][3:0] PERIOD_LAST = {
    4'(P4 - 1), 4'(P3 - 1), 4'(P2 - 1), 4'(P1 - 1), 4'(P0 - 1)
  };
  localparam logic [4:0][13:0] INIT_PAT = {INIT4, INIT3, INIT2, INIT1, INIT0};

  logic [23:0]       tick_cnt;
  logic              tick_due;
  logic [4:0][3:0]   lane_cnt;
  logic [4:0][13:0]  lane_pat;
  logic [4:0]        shift_due;
  logic              hit;
  logic              r_Hit_Prev;

  // Lane offset is only formed once the cell is known to be inside the road,
  // so the truncated 3-bit lane index is always 0..4.
  function automatic logic cell_occupied(input logic [4:0][13:0] pats,
                                         input logic [5:0]       col,
                                         input logic [5:0]       row);
    logic [2:0] lane;
    cell_occupied = 1'b0;
    if ((row >= ROW_FIRST) && (row <= ROW_LAST) && (col <= COL_LAST)) begin
      lane          = 3'(row - ROW_FIRST);
      cell_occupied = pats[lane][col[3:0]];
    end
  endfunction

  assign tick_due = i_Game_Active && (tick_cnt == TICK_LAST);

  always_comb begin
    shift_due = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      shift_due[k] = tick_due && (lane_cnt[k] == PERIOD_LAST[k]);
    end
  end

  assign hit = i_Game_Active && cell_occupied(lane_pat, i_Frogger_X, i_Frogger_Y);

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      tick_cnt <= '0;
      o_Tick   <= 1'b0;
    end else begin
      o_Tick <= tick_due;
      if (i_Game_Active) begin
        tick_cnt <= tick_due ? '0 : tick_cnt + 24'd1;
      end
    end
  end

  // Even lanes travel toward higher columns, odd lanes toward lower ones.
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      lane_cnt     <= '0;
      lane_pat     <= INIT_PAT;
      o_Lane_Shift <= '0;
    end else begin
      o_Lane_Shift <= shift_due;
      if (tick_due) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          if (shift_due[k]) begin
            lane_cnt[k] <= '0;
            if ((k % 2) == 0) begin
              lane_pat[k] <= {lane_pat[k][12:0], lane_pat[k][13]};
            end else begin
              lane_pat[k] <= {lane_pat[k][0], lane_pat[k][13:1]};
            end
          end else begin
            lane_cnt[k] <= lane_cnt[k] + 4'd1;
          end
        end
      end
    end
  end

  // Rising edge of the hit condition gives one pulse per entry into a car cell.
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_Hit_Prev    <= 1'b0;
      o_Collided    <= 1'b0;
      o_Car_Present <= 1'b0;
    end else begin
      r_Hit_Prev    <= hit;
      o_Collided    <= hit & ~r_Hit_Prev;
      o_Car_Present <= cell_occupied(lane_pat, i_Col_Count_Div, i_Row_Count_Div);
    end
  end

endmodule

// File: tb/tb_road_lane_ctrl.sv
// Self-checking bench for road_lane_ctrl: directed steps plus random stimulus
// against a model that derives lane contents from the count of active cycles.
module tb_road_lane_ctrl;

  localparam int TD   = 4;
  localparam int ROW0 = 8;

  logic       clk;
  logic       rst_n;
  logic       game_active;
  logic [5:0] frog_x;
  logic [5:0] frog_y;
  logic [5:0] col_div;
  logic [5:0] row_div;
  logic       collided;
  logic       car_present;
  logic       tick;
  logic [4:0] lane_shift;

  int          per_m  [5] = '{4, 3, 5, 2, 6};
  logic [13:0] init_m [5] = '{14'h0C03, 14'h0330, 14'h1818, 14'h0606, 14'h2040};

  int         n_cmp;
  int         n_fail;
  int         act_cycles;
  bit         hit_prev_m;
  bit         exp_coll;
  bit         exp_car;
  bit         exp_tick;
  logic [4:0] exp_shift;

  road_lane_ctrl #(.TICK_DIV(TD)) dut (
    .i_Clk          (clk),
    .i_Rst_N        (rst_n),
    .i_Game_Active  (game_active),
    .i_Frogger_X    (frog_x),
    .i_Frogger_Y    (frog_y),
    .i_Col_Count_Div(col_div),
    .i_Row_Count_Div(row_div),
    .o_Collided     (collided),
    .o_Car_Present  (car_present),
    .o_Tick         (tick),
    .o_Lane_Shift   (lane_shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane k after s shifts is its initial pattern rotated s places.
  function automatic bit m_occ(input int x, input int y, input int a);
    int lane, shifts, src;
    if (y < ROW0 || y > ROW0 + 4 || x < 0 || x > 13) return 1'b0;
    lane   = y - ROW0;
    shifts = ((a / TD) / per_m[lane]) % 14;
    src    = ((lane % 2) == 0) ? (x - shifts + 14) % 14 : (x + shifts) % 14;
    return init_m[lane][src];
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit act, input int fx, input int fy,
                               input int col, input int row);
    bit hit_m;
    game_active = act;
    frog_x      = 6'(fx);
    frog_y      = 6'(fy);
    col_div     = 6'(col);
    row_div     = 6'(row);
    exp_car     = m_occ(col, row, act_cycles);
    hit_m       = act && m_occ(fx, fy, act_cycles);
    exp_coll    = hit_m && !hit_prev_m;
    hit_prev_m  = hit_m;
    exp_tick    = 1'b0;
    exp_shift   = '0;
    if (act) begin
      act_cycles++;
      if ((act_cycles % TD) == 0) begin
        exp_tick = 1'b1;
        for (int k = 0; k < 5; k++) begin
          if (((act_cycles / TD) % per_m[k]) == 0) exp_shift[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput("tick", 8'(tick), 8'(exp_tick));
    checkOutput("lane_shift", 8'(lane_shift), 8'(exp_shift));
    checkOutput("collided", 8'(collided), 8'(exp_coll));
    checkOutput("car_present", 8'(car_present), 8'(exp_car));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_tick", 8'(tick), 8'd0);
    checkOutput("rst_lane_shift", 8'(lane_shift), 8'd0);
    checkOutput("rst_collided", 8'(collided), 8'd0);
    checkOutput("rst_car_present", 8'(car_present), 8'd0);
    act_cycles = 0;
    hit_prev_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Frozen read-back of every road cell through the render port.
  task automatic sweepLanes(input int fx, input int fy);
    int ones;
    for (int lane = 0; lane < 5; lane++) begin
      ones = 0;
      for (int c = 0; c < 14; c++) begin
        applyStimulus(1'b0, fx, fy, c, ROW0 + lane);
        if (car_present === 1'b1) ones++;
      end
      checkOutput($sformatf("popcount_lane%0d", lane), 8'(ones),
                  8'($countones(init_m[lane])));
    end
  endtask

  initial begin
    int  ticks_seen, pulses_seen, pulses_exp, car_x, car_y;
    bit  found;
    int  fx, fy;

    n_cmp       = 0;
    n_fail      = 0;
    act_cycles  = 0;
    hit_prev_m  = 1'b0;
    game_active = 1'b0;
    frog_x      = '0;
    frog_y      = '0;
    col_div     = '0;
    row_div     = '0;
    rst_n       = 1'b1;
    #2;

    doReset();
    sweepLanes(14, 0);

    ticks_seen = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 14, 0, 0, 0);
      if (tick === 1'b1) ticks_seen++;
    end
    checkOutput("tick_count_16", 8'(ticks_seen), 8'd4);
    sweepLanes(14, 0);

    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b1, 14, 0, 0, 0);
      found = exp_tick;
    end
    checkOutput("mid_reset_search", 8'(found), 8'd1);
    #2;
    doReset();
    sweepLanes(14, 0);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      applyStimulus(1'b1, 14, 0, 0, 0);
      found = exp_shift[1] && m_occ(0, 9, act_cycles) && !m_occ(0, 10, act_cycles);
    end
    checkOutput("frog_move_search", 8'(found), 8'd1);
    applyStimulus(1'b1, 0, 10, 0, 0);
    pulses_seen = 0;
    pulses_exp  = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 0, 9, 0, 9);
      if (collided === 1'b1) pulses_seen++;
      if (exp_coll) pulses_exp++;
    end
    checkOutput("frog_move_pulses", 8'(pulses_seen), 8'(pulses_exp));

    pulses_seen = 0;
    pulses_exp  = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, 5, 8, 5, 8);
      if (collided === 1'b1) pulses_seen++;
      if (exp_coll) pulses_exp++;
    end
    checkOutput("car_shift_pulses", 8'(pulses_seen), 8'(pulses_exp));

    pulses_seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (i < 50) applyStimulus(1'b1, 14 + (i % 50), ROW0 + (i % 5), 3, 12);
      else        applyStimulus(1'b1, i % 14, 13 + (i % 3) * 20, 3, 12);
      if (collided === 1'b1) pulses_seen++;
    end
    checkOutput("out_of_range_pulses", 8'(pulses_seen), 8'd0);

    found = 1'b0;
    car_x = 0;
    car_y = 0;
    for (int y = ROW0; y < ROW0 + 5; y++) begin
      for (int x = 0; x < 14; x++) begin
        if (!found && m_occ(x, y, act_cycles)) begin
          found = 1'b1;
          car_x = x;
          car_y = y;
        end
      end
    end
    checkOutput("freeze_car_search", 8'(found), 8'd1);
    pulses_seen = 0;
    for (int lane = 0; lane < 5; lane++) begin
      for (int c = 0; c < 14; c++) begin
        applyStimulus(1'b0, car_x, car_y, c, ROW0 + lane);
        if (tick === 1'b1 || lane_shift !== 5'd0 || collided === 1'b1) pulses_seen++;
      end
    end
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, car_x, car_y, i % 14, ROW0 + (i % 5));
      if (tick === 1'b1 || lane_shift !== 5'd0 || collided === 1'b1) pulses_seen++;
    end
    checkOutput("freeze_activity", 8'(pulses_seen), 8'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, car_x, car_y, 0, 0);

    fx = 0;
    fy = ROW0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        fx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
        fy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(6, 14));
      end
      applyStimulus($urandom_range(0, 7) != 0, fx, fy,
                    int'($urandom_range(0, 15)), int'($urandom_range(6, 15)));
    end
    sweepLanes(14, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
